rsa_key_derive: RTL and testbench
=================================

# rsa_key_derive

Derives the RSA modulus, totient and private exponent from a prime pair. It sits directly downstream of the prime generator and consumes its P/Q outputs once that block signals done. It computes N = P·Q with a sequential shift-add multiplier, then φ = N − P − Q + 1, then d = e⁻¹ mod φ with an iterative extended-Euclid loop. The loop uses a bit-serial restoring divider. Results feed the modular-exponentiation datapath.

## Interface
- WORD_WIDTH, 32: key width. P and Q are WORD_WIDTH/2 bits; N, φ, e and d are WORD_WIDTH bits. Must be even and ≥ 8.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin derivation. Sampled only in IDLE.
- P  in  WORD_WIDTH/2  first prime. Captured when start is accepted.
- Q  in  WORD_WIDTH/2  second prime. Captured when start is accepted.
- E  in  WORD_WIDTH  public exponent. Captured when start is accepted.
- done  out  1  one-cycle pulse; results valid.
- error  out  1  registered; valid with done. Held until the next accepted start.
- N  out  WORD_WIDTH  modulus P·Q.
- PHI  out  WORD_WIDTH  (P−1)(Q−1).
- D  out  WORD_WIDTH  private exponent; 0 when error=1.

## Operation
- States: IDLE, MUL, PHI_CALC, CHECK, DIV, UPDATE, FINISH, DONE.
- **IDLE**
  - On start=1: latch P, Q, E; clear the N accumulator, error and the loop registers; go to MUL.
  - start asserted in any other state is ignored.
- **MUL** (WORD_WIDTH/2 cycles)
  - LSB-first shift-add: if multiplier bit i is set, acc += P << i.
  - The accumulator is WORD_WIDTH bits; the product cannot overflow.
- **PHI_CALC** (1 cycle)
  - φ = N − P − Q + 1, computed in WORD_WIDTH bits.
  - Set error and go to FINISH if P<2, Q<2, E==0, or E≥φ.
  - Otherwise initialise r0=φ, r1=E, t0=0, t1=1 and go to CHECK.
- **CHECK** (1 cycle)
  - r1==0: go to FINISH.
  - Otherwise go to DIV.
- **DIV** (WORD_WIDTH cycles)
  - Restoring division r0 / r1, producing quotient bits MSB first.
  - In the same cycles, accumulate qt = 2·qt + qbit·t1 (Horner), so qt = q·t1 at exit.
  - Afterwards rem holds r0 mod r1.
- **UPDATE** (1 cycle)
  - (r0, r1) ← (r1, rem).
  - (t0, t1) ← (t1, t0 − qt).
  - Go to CHECK.
- **Arithmetic widths**: t0, t1 and qt are signed, WORD_WIDTH+2 bits. Magnitudes never exceed φ, so no wrap.
- **FINISH** (1 cycle)
  - If r0≠1 (gcd(E,φ)≠1), set error.
  - If error=1: D=0.
  - If error=0: D = t0 if t0≥0, else t0+φ.
  - N and PHI register the computed values; they are valid on the error path too.
- **DONE** (1 cycle): done=1, then go to IDLE.
- **Output holding**: outputs hold until the next accepted start, when error clears. N, PHI and D keep their old values until FINISH.
- **Reset**
  - rst=1 in any state, including mid-MUL or mid-DIV, returns to IDLE next edge.
  - Reset values: done=0, error=0, N=0, PHI=0, D=0; all internal registers are zeroed.
  - No done pulse is produced for an aborted run.

## Timing
- start is sampled in IDLE at edge T; the first MUL cycle is T+1.
- Let k = number of Euclid iterations (DIV passes). done is high in cycle T+1+WORD_WIDTH/2+3+k·(WORD_WIDTH+2).
- Error from PHI_CALC: done is high in cycle T+1+WORD_WIDTH/2+2.
- Back-to-back runs: start may be asserted in the cycle done is high; it is accepted on the following IDLE cycle.
- Minimum gap between done pulses is one IDLE cycle.

## Test plan
- **Textbook key**: WORD_WIDTH=32, P=61, Q=53, E=17.
  - Required: N=3233, PHI=3120, D=2753, error=0.
  - k=4; done exactly 155 cycles after the first MUL cycle.
- **Small key**: P=11, Q=13, E=7.
  - Required: N=143, PHI=120, D=103, error=0.
  - This case exercises the t0<0 correction path.
- **Non-coprime exponent**: P=7, Q=11, E=3 (φ=60).
  - Required: error=1, D=0, N=77, PHI=60.
  - done arrives after the full Euclid loop completes.
- **Input guards**: E=0, then E=φ=3120 with P=61, Q=53.
  - Required for each: error=1 with done at T+1+16+2; N=3233 and PHI=3120 still reported.
- **Reset mid-DIV**: assert rst for 1 cycle, 10 cycles into the first DIV of the P=61 run.
  - Required: no done pulse; all outputs 0.
  - A subsequent start gives the correct P=61 result.
- **Back-to-back with ignored start**:
  - Hold start high throughout the P=61 run; it must not restart mid-run.
  - Then start P=11 in the cycle done is high.
  - Required: the second run's results are correct, and error clears at its acceptance.

Source files
------------

// File: rtl/rsa_key_derive.sv
// Derives the RSA modulus N = P*Q, totient (P-1)(Q-1) and private exponent d = E^-1 mod phi.
// Uses a shift-add multiplier, then extended Euclid with a bit-serial restoring divider.
module rsa_key_derive #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD_WIDTH/2-1:0]   P,
    input  logic [WORD_WIDTH/2-1:0]   Q,
    input  logic [WORD_WIDTH-1:0]     E,
    output logic                      done,
    output logic                      error,
    output logic [WORD_WIDTH-1:0]     N,
    output logic [WORD_WIDTH-1:0]     PHI,
    output logic [WORD_WIDTH-1:0]     D
);

    localparam int W  = WORD_WIDTH;
    localparam int H  = WORD_WIDTH / 2;
    localparam int TW = WORD_WIDTH + 2;
    localparam int CW = $clog2(WORD_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE, MUL, PHI_CALC, CHECK, DIV, UPDATE, FINISH, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [H-1:0]          p_q, p_d;
    logic [H-1:0]          q_q, q_d;
    logic [W-1:0]          e_q, e_d;
    logic [W-1:0]          mcand_q, mcand_d;
    logic [H-1:0]          mplier_q, mplier_d;
    logic [W-1:0]          acc_q, acc_d;
    logic [W-1:0]          phi_q, phi_d;
    logic [W-1:0]          r0_q, r0_d;
    logic [W-1:0]          r1_q, r1_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [W-1:0]          dvd_q, dvd_d;
    logic signed [TW-1:0]  t0_q, t0_d;
    logic signed [TW-1:0]  t1_q, t1_d;
    logic signed [TW-1:0]  qt_q, qt_d;
    logic                  err_q, err_d;
    logic [W-1:0]          n_q, n_d;
    logic [W-1:0]          phi_out_q, phi_out_d;
    logic [W-1:0]          d_q, d_d;

    logic [W:0]            rem_shift;
    logic [W-1:0]          rem_sub;
    logic                  qbit;
    logic [W-1:0]          phi_calc;
    logic [W-1:0]          t0_fixed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            q_q       <= '0;
            e_q       <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            phi_q     <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            qt_q      <= '0;
            err_q     <= 1'b0;
            n_q       <= '0;
            phi_out_q <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            q_q       <= q_d;
            e_q       <= e_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            phi_q     <= phi_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            qt_q      <= qt_d;
            err_q     <= err_d;
            n_q       <= n_d;
            phi_out_q <= phi_out_d;
            d_q       <= d_d;
        end
    end

    // Restoring-division step: the subtraction only needs W bits because it is kept only when it fits.
    assign rem_shift = {rem_q, dvd_q[W-1]};
    assign qbit      = (rem_shift >= {1'b0, r1_q});
    assign rem_sub   = rem_shift[W-1:0] - r1_q;
    assign phi_calc  = acc_q - {{H{1'b0}}, p_q} - {{H{1'b0}}, q_q} + W'(1);
    assign t0_fixed  = t0_q[W-1:0] + phi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        q_d       = q_q;
        e_d       = e_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        phi_d     = phi_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        qt_d      = qt_q;
        err_d     = err_q;
        n_d       = n_q;
        phi_out_d = phi_out_q;
        d_d       = d_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d      = P;
                    q_d      = Q;
                    e_d      = E;
                    mcand_d  = {{H{1'b0}}, P};
                    mplier_d = Q;
                    acc_d    = '0;
                    err_d    = 1'b0;
                    r0_d     = '0;
                    r1_d     = '0;
                    rem_d    = '0;
                    dvd_d    = '0;
                    t0_d     = '0;
                    t1_d     = '0;
                    qt_d     = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(H - 1)) begin
                    cnt_d   = '0;
                    state_d = PHI_CALC;
                end
            end
            PHI_CALC: begin
                phi_d = phi_calc;
                if (p_q < H'(2) || q_q < H'(2) || e_q == '0 || e_q >= phi_calc) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    r0_d    = phi_calc;
                    r1_d    = e_q;
                    t0_d    = '0;
                    t1_d    = TW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (r1_q == '0) begin
                    state_d = FINISH;
                end else begin
                    rem_d   = '0;
                    dvd_d   = r0_q;
                    qt_d    = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = qbit ? rem_sub : rem_shift[W-1:0];
                dvd_d = dvd_q << 1;
                // Horner accumulation leaves qt = quotient * t1 when the divider finishes.
                qt_d  = (qt_q <<< 1) + (qbit ? t1_q : '0);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t0_q - qt_q;
                state_d = CHECK;
            end
            FINISH: begin
                n_d       = acc_q;
                phi_out_d = phi_q;
                if (err_q || r0_q != W'(1)) begin
                    err_d = 1'b1;
                    d_d   = '0;
                end else begin
                    d_d = t0_q[TW-1] ? t0_fixed : t0_q[W-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done  = (state_q == DONE);
    assign error = err_q;
    assign N     = n_q;
    assign PHI   = phi_out_q;
    assign D     = d_q;

endmodule

// File: tb/tb_rsa_key_derive.sv
// Directed bench for rsa_key_derive: known keys, guard errors, mid-run reset and back-to-back starts.
module tb_rsa_key_derive;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  P;
    logic [15:0]  Q;
    logic [31:0]  E;
    logic         done;
    logic         error;
    logic [31:0]  N;
    logic [31:0]  PHI;
    logic [31:0]  D;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  n_prev = '0;

    always #5 clk = ~clk;

    rsa_key_derive #(.WORD_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .P     (P),
        .Q     (Q),
        .E     (E),
        .done  (done),
        .error (error),
        .N     (N),
        .PHI   (PHI),
        .D     (D)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a start request and returns right after the accepting edge.
    task automatic launch(input logic [15:0] p, input logic [15:0] q, input logic [31:0] e);
        @(negedge clk);
        P     = p;
        Q     = q;
        E     = e;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Counts cycles from the first MUL cycle (count 1) to done, then checks the results.
    task automatic wait_check(input string tag, input int exp_cyc, input logic [31:0] en,
                              input logic [31:0] ephi, input logic [31:0] ed,
                              input logic eerr, input logic hold);
        int   cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_err_clear"}, {31'b0, error}, 32'd0);
                chk({tag, "_n_hold"}, N, n_prev);
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_N"}, N, en);
        chk({tag, "_PHI"}, PHI, ephi);
        chk({tag, "_D"}, D, ed);
        chk({tag, "_error"}, {31'b0, error}, {31'b0, eerr});
        n_prev = en;
        $display("run %s P=%0d Q=%0d E=%0d -> N=%0d PHI=%0d D=%0d error=%0d cycles=%0d",
                 tag, P, Q, E, N, PHI, D, error, cyc);
    endtask

    initial begin
        int   dseen;
        rst   = 1'b1;
        start = 1'b0;
        P     = '0;
        Q     = '0;
        E     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_error", {31'b0, error}, 32'd0);
        chk("reset_N", N, 32'd0);
        chk("reset_PHI", PHI, 32'd0);
        chk("reset_D", D, 32'd0);

        launch(16'd61, 16'd53, 32'd17);
        wait_check("textbook", 156, 32'd3233, 32'd3120, 32'd2753, 1'b0, 1'b0);
        @(negedge clk);
        chk("textbook_done_pulse", {31'b0, done}, 32'd0);

        launch(16'd11, 16'd13, 32'd7);
        wait_check("small", 88, 32'd143, 32'd120, 32'd103, 1'b0, 1'b0);

        launch(16'd7, 16'd11, 32'd3);
        wait_check("noncoprime", 54, 32'd77, 32'd60, 32'd0, 1'b1, 1'b0);

        launch(16'd61, 16'd53, 32'd0);
        wait_check("guard_e0", 19, 32'd3233, 32'd3120, 32'd0, 1'b1, 1'b0);

        launch(16'd61, 16'd53, 32'd3120);
        wait_check("guard_ephi", 19, 32'd3233, 32'd3120, 32'd0, 1'b1, 1'b0);

        // Abort ten cycles into the first divide pass.
        launch(16'd61, 16'd53, 32'd17);
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_error", {31'b0, error}, 32'd0);
        chk("abort_N", N, 32'd0);
        chk("abort_PHI", PHI, 32'd0);
        chk("abort_D", D, 32'd0);
        dseen = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("abort_no_done", dseen, 32'd0);
        $display("run abort reset mid-DIV, done pulses afterwards=%0d", dseen);
        n_prev = '0;

        launch(16'd61, 16'd53, 32'd17);
        wait_check("after_abort", 156, 32'd3233, 32'd3120, 32'd2753, 1'b0, 1'b0);

        // Start held high for the whole run; next key presented while done is high.
        launch(16'd61, 16'd53, 32'd17);
        wait_check("held_start", 156, 32'd3233, 32'd3120, 32'd2753, 1'b0, 1'b1);
        P = 16'd11;
        Q = 16'd13;
        E = 32'd7;
        @(posedge clk);
        @(posedge clk);
        wait_check("back_to_back", 88, 32'd143, 32'd120, 32'd103, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_done_pulse", {31'b0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
